// File: rtl/bmem_line_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : bmem_line_adapter
//  Purpose  : Initiator side of the burst-memory (bmem) interface. Turns one
//             cacheline read or writeback from the last-level cache into a
//             BURST_LEN-beat burst of BEAT_W-bit beats, and returns a single
//             cycle completion pulse to the cache.
//  Ports    : clk         - clock
//             rst         - asynchronous reset, active low (0 = in reset)
//             line_addr   - cacheline byte address from the cache
//             line_read   - cacheline read request (sampled in IDLE only)
//             line_write  - cacheline writeback request (wins over read)
//             line_wdata  - writeback data
//             line_rdata  - assembled read data, stable until next read beat
//             line_resp   - one-cycle completion pulse
//             bmem_addr   - line-aligned burst base address (0 when idle)
//             bmem_read   - one-cycle burst read command
//             bmem_write  - write beat valid
//             bmem_wdata  - write beat data
//             bmem_rdata  - read beat data
//             bmem_resp   - read beat valid / write completion
//  Revision : 1.0 - initial release
// ============================================================================
module bmem_line_adapter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int LINE_W    = BEAT_W * BURST_LEN,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    // Byte-offset bits within one line; these are forced to zero on bmem_addr.
    localparam int c_OFS_W = $clog2(LINE_W / 8);
    localparam int c_CNT_W = $clog2(BURST_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_DATA = 3'd3,
        S_WR_ACK  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [c_CNT_W-1:0]           r_cnt;
    logic [ADDR_W-c_OFS_W-1:0]    r_addr;
    logic [LINE_W-1:0]            r_wdata;
    logic [LINE_W-1:0]            r_rdata;

    // Only the line-number part of the address is kept; the offset is dropped.
    logic w_unused_ofs;
    assign w_unused_ofs = ^line_addr[c_OFS_W-1:0];

    // ------------------------------------------------------------------------
    // State, counter and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (line_write) begin
                        r_addr  <= line_addr[ADDR_W-1:c_OFS_W];
                        r_wdata <= line_wdata;
                        r_cnt   <= '0;
                    end else if (line_read) begin
                        r_addr  <= line_addr[ADDR_W-1:c_OFS_W];
                    end
                end
                S_RD_REQ: begin
                    r_cnt <= '0;
                end
                S_RD_DATA: begin
                    // Gaps in the beat stream simply hold the counter.
                    if (bmem_resp) begin
                        for (int i = 0; i < BURST_LEN; i++) begin
                            if (r_cnt == c_CNT_W'(i)) begin
                                r_rdata[i*BEAT_W +: BEAT_W] <= bmem_rdata;
                            end
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR_DATA: begin
                    // Write beats stream out with no per-beat handshake.
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs. Outputs decode the registered state only, so
    // none of them has a combinational path from the bmem_* inputs.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        line_resp   = 1'b0;
        bmem_addr   = '0;
        bmem_wdata  = '0;

        if (r_state != S_IDLE) begin
            bmem_addr = {r_addr, {c_OFS_W{1'b0}}};
        end

        case (r_state)
            S_IDLE: begin
                if (line_write) begin
                    w_state_nxt = S_WR_DATA;
                end else if (line_read) begin
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                bmem_read   = 1'b1;
                w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (bmem_resp && (r_cnt == c_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WR_DATA: begin
                bmem_write = 1'b1;
                for (int i = 0; i < BURST_LEN; i++) begin
                    if (r_cnt == c_CNT_W'(i)) begin
                        bmem_wdata = r_wdata[i*BEAT_W +: BEAT_W];
                    end
                end
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                if (bmem_resp) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                line_resp   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign line_rdata = r_rdata;

endmodule
`default_nettype wire

// File: doc/bmem_line_adapter.md
Name: bmem_line_adapter

Overview:
- Initiator side of the burst-memory (bmem) interface.
- Sits between the CPU's last-level cache and the testbench burst memory responder.
- Converts one 256-bit cacheline read or writeback into a 4-beat, 64-bit burst and returns a single-cycle completion to the cache.

Parameters:
BEAT_W, 64, width of one bmem data beat
BURST_LEN, 4, beats per burst
LINE_W, BEAT_W*BURST_LEN (256), cacheline width
ADDR_W, 32, address width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low (0 = in reset)
line_addr  input  ADDR_W  cacheline byte address from cache
line_read  input  1  cacheline read request
line_write  input  1  cacheline writeback request
line_wdata  input  LINE_W  writeback data
line_rdata  output  LINE_W  assembled read data
line_resp  output  1  one-cycle completion pulse
bmem_addr  output  ADDR_W  burst base address
bmem_read  output  1  burst read command
bmem_write  output  1  burst write beat valid
bmem_wdata  output  BEAT_W  write beat
bmem_rdata  input  BEAT_W  read beat
bmem_resp  input  1  read beat valid / write completion

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0. All outputs 0, including line_rdata and bmem_addr.
- Reset mid-burst: abort immediately; no line_resp is issued. Any bmem_resp seen in IDLE is ignored.
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_ACK, DONE.
- IDLE: sample requests.
  - line_write=1 -> latch line_addr and line_wdata, go to WR_DATA. Write wins if both read and write are high.
  - Otherwise line_read=1 -> latch line_addr, go to RD_REQ.
  - Requests are captured only in IDLE; inputs are don't-care in all other states.
- Address: bmem_addr = {latched_addr[ADDR_W-1:5], 5'b0}, i.e. 32-byte aligned. Driven in every non-IDLE state, 0 in IDLE.
- RD_REQ: bmem_read=1 for exactly one cycle, then go to RD_DATA with counter=0.
- RD_DATA:
  - Each cycle with bmem_resp=1 stores bmem_rdata into line_rdata[counter*64 +: 64] and increments the counter.
  - Gaps (bmem_resp=0) are allowed and simply hold state.
  - On the beat where counter==BURST_LEN-1, go to DONE.
- WR_DATA:
  - bmem_write=1 on BURST_LEN consecutive cycles; bmem_wdata = line_wdata[counter*64 +: 64].
  - No per-beat handshake. bmem_resp in WR_DATA is ignored.
  - After beat 3, go to WR_ACK.
- WR_ACK: bmem_write=0; wait for bmem_resp=1, then go to DONE.
- DONE: line_resp=1 for one cycle, then go to IDLE.
  - line_rdata stays stable from DONE until the next read's first beat.
  - A write does not modify line_rdata.
- Latency: request in IDLE at cycle 0 -> bmem_read at cycle 1. Beats arriving back-to-back at cycles 2-5 -> line_resp at cycle 6.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after DONE.
- Counter: 2 bits, wraps 3->0. Reset to 0 on entry to RD_DATA and WR_DATA.
- No outputs are combinationally dependent on bmem_* inputs.

Test Plan:
- Read, back-to-back beats: line_read, addr 0x6000_0024; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> bmem_addr=0x6000_0020 with bmem_read for one cycle; line_resp 6 cycles after request; line_rdata = {44..,33..,22..,11..}.
- Read with gaps: same beats, 2 idle cycles between beats 1 and 2 -> identical line_rdata; line_resp delayed by exactly 2 cycles.
- Writeback: line_write, addr 0x6000_0100, wdata = {64'hD,64'hC,64'hB,64'hA}; resp 3 cycles after last beat -> bmem_write high 4 consecutive cycles carrying A,B,C,D; one line_resp cycle after resp; line_rdata unchanged.
- Simultaneous read+write in IDLE -> write burst issued, bmem_read never asserted.
- Reset after 2 read beats, then a stray bmem_resp in IDLE -> all outputs 0, no line_resp. A following read completes correctly with a fresh counter.
- Back-to-back read then write -> second request accepted in the cycle after line_resp; no extra bubble.
